onehot_reg_bank: RTL

//  4-entry register bank downstream of the 2-to-4 write-address decoder; consumes its one-hot outputs as write selects.

---
 rtl/regbank_pkg.sv | 19 +
 rtl/onehot_check.sv | 26 ++
 rtl/onehot_reg_bank.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regbank_pkg.sv
// Shared sizing, index type and one-hot encoder for the 4-entry register bank.
package regbank_pkg;

  localparam int NUM_ENTRIES = 4;
  localparam int IDX_W       = 2;

  typedef logic [IDX_W-1:0] idx_t;

  // Only meaningful for a one-hot input; the highest set bit wins otherwise.
  function automatic idx_t onehot_to_idx(input logic [NUM_ENTRIES-1:0] sel);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/onehot_check.sv
// Combinational classifier for the decoder's write select: none, exactly one, or several bits set.
module onehot_check
  import regbank_pkg::*;
(
  input  logic [NUM_ENTRIES-1:0] sel,
  output logic                   is_zero,
  output logic                   is_onehot,
  output logic                   is_multi,
  output idx_t                   idx
);

  logic [2:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      pop = pop + 3'(sel[i]);
    end
  end

  assign is_zero   = (pop == 3'd0);
  assign is_onehot = (pop == 3'd1);
  assign is_multi  = (pop > 3'd1);
  assign idx       = onehot_to_idx(sel);

endmodule

// File: rtl/onehot_reg_bank.sv
// 4-entry register bank written through one-hot selects via a one-cycle stage, two registered read ports.
// Define RD_BYPASS_EN to let a read of the entry committing on the same edge return the staged data.
module onehot_reg_bank
  import regbank_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ENTRIES-1:0] wr_sel,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [IDX_W-1:0]       rd_addr_a,
  input  logic [IDX_W-1:0]       rd_addr_b,
  input  logic                   clear,
  input  logic                   err_clr,
  output logic [DATA_W-1:0]      rd_data_a,
  output logic [DATA_W-1:0]      rd_data_b,
  output logic                   rd_valid_a,
  output logic                   rd_valid_b,
  output logic                   onehot_err,
  output logic [CNT_W-1:0]       wr_count
);

  logic                   sel_is_zero;
  logic                   sel_is_onehot;
  logic                   sel_is_multi;
  idx_t                   sel_idx;

  logic                   stage_v;
  idx_t                   stage_idx;
  logic [DATA_W-1:0]      stage_data;

  logic [DATA_W-1:0]      entry [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] valid_next;

  logic [DATA_W-1:0]      rd_next_data_a;
  logic [DATA_W-1:0]      rd_next_data_b;
  logic                   rd_next_valid_a;
  logic                   rd_next_valid_b;

  logic                   stage_load;

  onehot_check u_onehot_check (
    .sel       (wr_sel),
    .is_zero   (sel_is_zero),
    .is_onehot (sel_is_onehot),
    .is_multi  (sel_is_multi),
    .idx       (sel_idx)
  );

  assign stage_load = sel_is_onehot && !sel_is_zero;

  // A commit on the same edge as clear keeps its entry valid.
  always_comb begin
    valid_next = clear ? '0 : valid;
    if (stage_v) valid_next[stage_idx] = 1'b1;
  end

  always_comb begin
    rd_next_data_a  = entry[rd_addr_a];
    rd_next_valid_a = valid[rd_addr_a];
    rd_next_data_b  = entry[rd_addr_b];
    rd_next_valid_b = valid[rd_addr_b];
`ifdef RD_BYPASS_EN
    if (stage_v && (rd_addr_a == stage_idx)) begin
      rd_next_data_a  = stage_data;
      rd_next_valid_a = 1'b1;
    end
    if (stage_v && (rd_addr_b == stage_idx)) begin
      rd_next_data_b  = stage_data;
      rd_next_valid_b = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_v    <= 1'b0;
      stage_idx  <= '0;
      stage_data <= '0;
    end else begin
      stage_v <= stage_load;
      if (stage_load) begin
        stage_idx  <= sel_idx;
        stage_data <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry[i] <= '0;
      valid    <= '0;
      wr_count <= '0;
    end else begin
      valid <= valid_next;
      if (stage_v) begin
        entry[stage_idx] <= stage_data;
        wr_count         <= wr_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
    end else begin
      rd_data_a  <= rd_next_data_a;
      rd_data_b  <= rd_next_data_b;
      rd_valid_a <= rd_next_valid_a;
      rd_valid_b <= rd_next_valid_b;
    end
  end

  // A new illegal select outranks err_clr on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (sel_is_multi) begin
      onehot_err <= 1'b1;
    end else if (err_clr) begin
      onehot_err <= 1'b0;
    end
  end

endmodule
